wb_unit: RTL and testbench
==========================

# wb_unit

Writeback unit for the rysy core: the writer side of the register file. Accepts completed results from the ALU and load paths over valid/ready handshakes, aligns and extends load data, orders results in a small FIFO, and drains one entry per cycle onto the register file write port (`rd`, `rd_d`, `reg_wr`). It sits between the execute/memory stages and `reg_file`, and is the only driver of the register file write port.

## Interface

- `ADDR_LEN`, 5: register address width.
- `FIFO_DEPTH`, 4: result FIFO entries; power of two, ≥ 2.
- `clk` in 1: clock, all state on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `alu_valid` in 1: ALU result offered.
- `alu_ready` out 1: ALU result accepted when `alu_valid & alu_ready`.
- `alu_rd` in ADDR_LEN: ALU destination register.
- `alu_d` in `REG_LEN`: ALU result.
- `ld_valid` in 1: load result offered.
- `ld_ready` out 1: load result accepted when `ld_valid & ld_ready`.
- `ld_rd` in ADDR_LEN: load destination register.
- `ld_data` in `REG_LEN`: raw aligned memory word.
- `ld_funct3` in 3: load type.
- `ld_addr_lo` in 2: byte offset of the load address.
- `rd` out ADDR_LEN: register file write address.
- `rd_d` out `REG_LEN`: register file write data.
- `reg_wr` out 1: register file write enable.
- `fifo_count` out $clog2(FIFO_DEPTH)+1: occupied entries.

## Operation

- Storage: circular FIFO, `FIFO_DEPTH` entries of {rd, data}; read/write pointers wrap modulo depth; separate occupancy count.
- Ready rules, from registered count only (no combinational path valid→ready): `free = FIFO_DEPTH - count`; `alu_ready = free ≥ 1`; `ld_ready = free ≥ 2`.
- Both channels may be accepted in one cycle; load entry enqueued ahead of ALU entry (load belongs to the older instruction).
- Entries with destination 0 complete the handshake but are not enqueued and never produce `reg_wr`.
- Load alignment (`ld_funct3`): 000 LB, sign-extended byte `ld_addr_lo`; 001 LH, sign-extended halfword `ld_addr_lo[1]`; 010 LW, full word; 100 LBU, zero-extended byte; 101 LHU, zero-extended halfword; any other encoding treated as LW. `ld_addr_lo[0]` ignored for halfwords.
- Drain: every cycle FIFO is non-empty, head presented on `rd`/`rd_d` with `reg_wr = 1` and popped at the edge. Empty FIFO: `reg_wr = 0`, `rd`/`rd_d` hold last head storage value.
- Push and pop in the same cycle permitted at any occupancy reachable under the ready rules; count updates by pushes − pop.

## Timing

- Reset: count 0, pointers 0, storage 0; `reg_wr = 0`, `rd = 0`, `rd_d = 0`, `fifo_count = 0`, both readies 1 in the first cycle after reset. During the `rst` cycle readies are 0 and nothing is accepted.
- Reset mid-operation discards all queued entries; no write issued in the reset cycle or after.
- Latency: result accepted in cycle N into empty FIFO → `reg_wr = 1` in cycle N+1; register file updated at end of N+1.
- Throughput: one write per cycle; two accepts per cycle bounded by readies.
- Outputs driven from storage registers and pointers only; no input-to-output combinational path.

## Configuration

- `WB_FORWARD_EN` defined: adds inputs `fwd_rs1`, `fwd_rs2` (ADDR_LEN) and outputs `fwd_rs1_hit`, `fwd_rs1_d`, `fwd_rs2_hit`, `fwd_rs2_d`; combinational search of valid FIFO entries, youngest match wins; address 0 never hits; miss drives data 0.
- Undefined: ports and search logic absent; the pipeline stalls on pending writes instead.

## Structure

- `rysy_pkg.vh`: existing `REG_LEN`, `REG_NUM`; add `WB_FIFO_DEPTH` default and load funct3 constants (`F3_LB`, `F3_LH`, `F3_LW`, `F3_LBU`, `F3_LHU`).
- Sub-module `wb_load_align`: combinational extract/extend of `ld_data` by `ld_funct3` and `ld_addr_lo`.

## Test plan

- Reset then ALU x5 = 0x0000_1234 → cycle+1: `reg_wr = 1`, `rd = 5`, `rd_d = 0x0000_1234`; next cycle `reg_wr = 0`.
- Same-cycle load x7 (LW 0xDEAD_BEEF) and ALU x7 = 1 → two writes: 0xDEAD_BEEF then 1; final x7 = 1.
- `ld_data = 0x80FF_7F01`: LB off 3 → 0xFFFF_FF80; LBU off 2 → 0x0000_00FF; LH off 2 → 0xFFFF_80FF; LHU off 0 → 0x0000_7F01.
- Both channels valid every cycle, depth 4 → `ld_ready` drops when count ≥ 3, `alu_ready` when count = 4; no entry lost or reordered; write order matches accept order.
- ALU write to x0 with empty FIFO → handshake completes, `fifo_count` stays 0, `reg_wr` stays 0.
- `rst` asserted with 3 entries queued → next cycle count 0, `reg_wr = 0`, readies 1; no stale writes afterwards.

Source files
------------

// File: rtl/wb_unit_pkg.sv
// wb_unit_pkg: register file sizing, FIFO depth default and load funct3 encodings for the writeback unit
package wb_unit_pkg;
  localparam int REG_LEN = 32;
  localparam int REG_NUM = 32;
  localparam int WB_FIFO_DEPTH = 4;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
endpackage

// File: rtl/wb_load_align.sv
// wb_load_align: extracts and sign/zero-extends the loaded byte, halfword or word from the raw memory word
module wb_load_align
  import wb_unit_pkg::*;
(
  input  logic [REG_LEN-1:0] data,
  input  logic [2:0]         funct3,
  input  logic [1:0]         addr_lo,
  output logic [REG_LEN-1:0] q
);
  logic [7:0]  b;
  logic [15:0] h;
  assign b = data[addr_lo*8 +: 8];
  assign h = addr_lo[1] ? data[31:16] : data[15:0];
  // Unlisted encodings fall through to a full-word load
  always_comb begin
    q = funct3 == F3_LB  ? {{(REG_LEN-8){b[7]}}, b} :
        funct3 == F3_LH  ? {{(REG_LEN-16){h[15]}}, h} :
        funct3 == F3_LBU ? {{(REG_LEN-8){1'b0}}, b} :
        funct3 == F3_LHU ? {{(REG_LEN-16){1'b0}}, h} :
        data;
  end
endmodule

// File: rtl/wb_unit.sv
// wb_unit: writeback FIFO merging ALU and load results onto the register file write port; WB_FORWARD_EN adds FIFO forwarding ports
module wb_unit
  import wb_unit_pkg::*;
#(
  parameter int ADDR_LEN   = 5,
  parameter int FIFO_DEPTH = WB_FIFO_DEPTH
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            alu_valid,
  output logic                            alu_ready,
  input  logic [ADDR_LEN-1:0]             alu_rd,
  input  logic [REG_LEN-1:0]              alu_d,
  input  logic                            ld_valid,
  output logic                            ld_ready,
  input  logic [ADDR_LEN-1:0]             ld_rd,
  input  logic [REG_LEN-1:0]              ld_data,
  input  logic [2:0]                      ld_funct3,
  input  logic [1:0]                      ld_addr_lo,
`ifdef WB_FORWARD_EN
  input  logic [ADDR_LEN-1:0]             fwd_rs1,
  input  logic [ADDR_LEN-1:0]             fwd_rs2,
  output logic                            fwd_rs1_hit,
  output logic [REG_LEN-1:0]              fwd_rs1_d,
  output logic                            fwd_rs2_hit,
  output logic [REG_LEN-1:0]              fwd_rs2_d,
`endif
  output logic [ADDR_LEN-1:0]             rd,
  output logic [REG_LEN-1:0]              rd_d,
  output logic                            reg_wr,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  logic [ADDR_LEN-1:0] mem_rd [FIFO_DEPTH];
  logic [REG_LEN-1:0]  mem_d  [FIFO_DEPTH];
  logic [PW-1:0]       wptr, rptr, alu_slot;
  logic [CW-1:0]       count;
  logic [REG_LEN-1:0]  ld_q;
  logic                ld_push, alu_push, pop;
  wb_load_align u_align (
    .data    (ld_data),
    .funct3  (ld_funct3),
    .addr_lo (ld_addr_lo),
    .q       (ld_q)
  );
  // A load needs two free slots so that a same-cycle ALU result always fits behind it
  assign alu_ready  = !rst && count < CW'(FIFO_DEPTH);
  assign ld_ready   = !rst && count < CW'(FIFO_DEPTH - 1);
  assign ld_push    = ld_valid && ld_ready && ld_rd != '0;
  assign alu_push   = alu_valid && alu_ready && alu_rd != '0;
  assign pop        = count != '0;
  assign alu_slot   = wptr + PW'(ld_push);
  assign rd         = mem_rd[rptr];
  assign rd_d       = mem_d[rptr];
  assign reg_wr     = !rst && pop;
  assign fifo_count = count;
  // Load is enqueued ahead of the ALU result because it belongs to the older instruction
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_rd[i] <= '0;
        mem_d[i]  <= '0;
      end
    end else begin
      if (ld_push) begin
        mem_rd[wptr] <= ld_rd;
        mem_d[wptr]  <= ld_q;
      end
      if (alu_push) begin
        mem_rd[alu_slot] <= alu_rd;
        mem_d[alu_slot]  <= alu_d;
      end
      wptr  <= wptr + PW'(ld_push) + PW'(alu_push);
      rptr  <= rptr + PW'(pop);
      count <= count + CW'(ld_push) + CW'(alu_push) - CW'(pop);
    end
  end
`ifdef WB_FORWARD_EN
  // Scan oldest to youngest so the youngest matching entry wins
  always_comb begin
    fwd_rs1_hit = 1'b0;
    fwd_rs1_d   = '0;
    fwd_rs2_hit = 1'b0;
    fwd_rs2_d   = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (CW'(i) < count && fwd_rs1 != '0 && mem_rd[rptr + PW'(i)] == fwd_rs1) begin
        fwd_rs1_hit = 1'b1;
        fwd_rs1_d   = mem_d[rptr + PW'(i)];
      end
      if (CW'(i) < count && fwd_rs2 != '0 && mem_rd[rptr + PW'(i)] == fwd_rs2) begin
        fwd_rs2_hit = 1'b1;
        fwd_rs2_d   = mem_d[rptr + PW'(i)];
      end
    end
  end
`endif
endmodule

// File: tb/tb_wb_unit.sv
// tb_wb_unit: directed self-checking bench for wb_unit
module tb_wb_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        alu_valid = 1'b0, ld_valid = 1'b0;
  logic        alu_ready, ld_ready, reg_wr;
  logic [4:0]  alu_rd = '0, ld_rd = '0, rd;
  logic [31:0] alu_d = '0, ld_data = '0, rd_d;
  logic [2:0]  ld_funct3 = 3'b010;
  logic [1:0]  ld_addr_lo = '0;
  logic [2:0]  fifo_count;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  wb_unit dut (
    .clk        (clk),
    .rst        (rst),
    .alu_valid  (alu_valid),
    .alu_ready  (alu_ready),
    .alu_rd     (alu_rd),
    .alu_d      (alu_d),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_rd      (ld_rd),
    .ld_data    (ld_data),
    .ld_funct3  (ld_funct3),
    .ld_addr_lo (ld_addr_lo),
    .rd         (rd),
    .rd_d       (rd_d),
    .reg_wr     (reg_wr),
    .fifo_count (fifo_count)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    alu_valid = 1'b0;
    ld_valid  = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step();
    step();
    checks++; if (alu_ready !== 1'b0) begin errors++; $display("FAIL rst_alu_ready got=%0b exp=0", alu_ready); end
    checks++; if (ld_ready !== 1'b0) begin errors++; $display("FAIL rst_ld_ready got=%0b exp=0", ld_ready); end
    rst = 1'b0;
    step();
    checks++; if (reg_wr !== 1'b0) begin errors++; $display("FAIL reset_reg_wr got=%0b exp=0", reg_wr); end
    checks++; if (rd !== 5'd0) begin errors++; $display("FAIL reset_rd got=%0d exp=0", rd); end
    checks++; if (rd_d !== 32'd0) begin errors++; $display("FAIL reset_rd_d got=%h exp=0", rd_d); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", fifo_count); end
    checks++; if (alu_ready !== 1'b1 || ld_ready !== 1'b1) begin errors++; $display("FAIL reset_readies got=%0b%0b exp=11", alu_ready, ld_ready); end
  endtask

  task automatic test_alu_write;
    alu_valid = 1'b1; alu_rd = 5'd5; alu_d = 32'h0000_1234;
    step();
    idle();
    checks++; if (reg_wr !== 1'b1) begin errors++; $display("FAIL alu_reg_wr got=%0b exp=1", reg_wr); end
    checks++; if (rd !== 5'd5) begin errors++; $display("FAIL alu_rd got=%0d exp=5", rd); end
    checks++; if (rd_d !== 32'h0000_1234) begin errors++; $display("FAIL alu_rd_d got=%h exp=00001234", rd_d); end
    step();
    checks++; if (reg_wr !== 1'b0) begin errors++; $display("FAIL alu_done_reg_wr got=%0b exp=0", reg_wr); end
  endtask

  task automatic test_same_cycle;
    logic [31:0] x7;
    ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'hDEAD_BEEF; ld_funct3 = 3'b010; ld_addr_lo = 2'd0;
    alu_valid = 1'b1; alu_rd = 5'd7; alu_d = 32'd1;
    step();
    idle();
    checks++; if (fifo_count !== 3'd2) begin errors++; $display("FAIL both_count got=%0d exp=2", fifo_count); end
    checks++; if (reg_wr !== 1'b1 || rd !== 5'd7 || rd_d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL both_first got=%0b/%0d/%h exp=1/7/deadbeef", reg_wr, rd, rd_d); end
    x7 = rd_d;
    step();
    checks++; if (reg_wr !== 1'b1 || rd !== 5'd7 || rd_d !== 32'd1) begin errors++; $display("FAIL both_second got=%0b/%0d/%h exp=1/7/00000001", reg_wr, rd, rd_d); end
    if (reg_wr && rd == 5'd7) x7 = rd_d;
    step();
    checks++; if (reg_wr !== 1'b0) begin errors++; $display("FAIL both_done got=%0b exp=0", reg_wr); end
    checks++; if (x7 !== 32'd1) begin errors++; $display("FAIL both_final_x7 got=%h exp=00000001", x7); end
  endtask

  task automatic test_load_align;
    logic [2:0]  f3  [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
    logic [1:0]  off [4] = '{2'd3, 2'd2, 2'd2, 2'd0};
    logic [31:0] exp [4] = '{32'hFFFF_FF80, 32'h0000_00FF, 32'hFFFF_80FF, 32'h0000_7F01};
    for (int i = 0; i < 4; i++) begin
      ld_valid = 1'b1; ld_rd = 5'd9; ld_data = 32'h80FF_7F01; ld_funct3 = f3[i]; ld_addr_lo = off[i];
      step();
      idle();
      checks++; if (reg_wr !== 1'b1 || rd_d !== exp[i]) begin errors++; $display("FAIL align_%0d got=%0b/%h exp=1/%h", i, reg_wr, rd_d, exp[i]); end
      step();
    end
    ld_funct3 = 3'b010; ld_addr_lo = 2'd0;
  endtask

  task automatic test_back_to_back;
    logic [36:0] q [$];
    logic [36:0] head;
    int n;
    for (int c = 0; c < 20; c++) begin
      n = q.size();
      checks++; if (fifo_count !== 3'(n)) begin errors++; $display("FAIL b2b_count_%0d got=%0d exp=%0d", c, fifo_count, n); end
      checks++; if (ld_ready !== (n <= 2) || alu_ready !== (n <= 3)) begin errors++; $display("FAIL b2b_ready_%0d got=%0b%0b exp=%0b%0b", c, ld_ready, alu_ready, n <= 2, n <= 3); end
      checks++; if (reg_wr !== (n != 0)) begin errors++; $display("FAIL b2b_wr_%0d got=%0b exp=%0b", c, reg_wr, n != 0); end
      if (n != 0) begin
        head = q.pop_front();
        checks++; if ({rd, rd_d} !== head) begin errors++; $display("FAIL b2b_data_%0d got=%0d/%h exp=%0d/%h", c, rd, rd_d, head[36:32], head[31:0]); end
      end
      if (c < 12) begin
        ld_valid = 1'b1; ld_rd = 5'(1 + c); ld_data = 32'hA000_0000 + 32'(c);
        alu_valid = 1'b1; alu_rd = 5'(20 + (c % 10)); alu_d = 32'hB000_0000 + 32'(c);
        if (n <= 2) q.push_back({ld_rd, ld_data});
        if (n <= 3) q.push_back({alu_rd, alu_d});
      end else idle();
      step();
    end
    checks++; if (q.size() != 0 || fifo_count !== 3'd0) begin errors++; $display("FAIL b2b_drained got=%0d exp=0", fifo_count); end
  endtask

  task automatic test_x0;
    alu_valid = 1'b1; alu_rd = 5'd0; alu_d = 32'h5555_5555;
    #1;
    checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL x0_ready got=%0b exp=1", alu_ready); end
    step();
    idle();
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL x0_count got=%0d exp=0", fifo_count); end
    checks++; if (reg_wr !== 1'b0) begin errors++; $display("FAIL x0_reg_wr got=%0b exp=0", reg_wr); end
    step();
    checks++; if (reg_wr !== 1'b0) begin errors++; $display("FAIL x0_reg_wr2 got=%0b exp=0", reg_wr); end
  endtask

  task automatic test_reset_mid;
    for (int c = 0; c < 2; c++) begin
      ld_valid = 1'b1; ld_rd = 5'(3 + 2 * c); ld_data = 32'hC0DE_0000 + 32'(c);
      alu_valid = 1'b1; alu_rd = 5'(4 + 2 * c); alu_d = 32'hF00D_0000 + 32'(c);
      step();
    end
    idle();
    checks++; if (fifo_count !== 3'd3) begin errors++; $display("FAIL mid_count got=%0d exp=3", fifo_count); end
    rst = 1'b1;
    #1;
    checks++; if (reg_wr !== 1'b0) begin errors++; $display("FAIL mid_rst_reg_wr got=%0b exp=0", reg_wr); end
    checks++; if (alu_ready !== 1'b0 || ld_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_ready got=%0b%0b exp=00", alu_ready, ld_ready); end
    step();
    rst = 1'b0;
    #1;
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL mid_after_count got=%0d exp=0", fifo_count); end
    checks++; if (alu_ready !== 1'b1 || ld_ready !== 1'b1) begin errors++; $display("FAIL mid_after_ready got=%0b%0b exp=11", alu_ready, ld_ready); end
    checks++; if (rd !== 5'd0 || rd_d !== 32'd0) begin errors++; $display("FAIL mid_after_storage got=%0d/%h exp=0/0", rd, rd_d); end
    for (int c = 0; c < 4; c++) begin
      checks++; if (reg_wr !== 1'b0) begin errors++; $display("FAIL mid_stale_%0d got=%0b exp=0", c, reg_wr); end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_alu_write();
    test_same_cycle();
    test_load_align();
    test_back_to_back();
    test_x0();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
